// File: rtl/lru_state_table.sv
// ============================================================================
// Module      : lru_state_table
// Description : Per-set 2-bit LRU storage for a 2-way set-associative cache,
//               with a one-set-per-cycle flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lru_state_table #(
    parameter int INDEX_WIDTH = 2,
    parameter int NUM_SETS    = 2**INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [1:0]             current_lru,
    input  logic                   access_valid,
    input  logic [INDEX_WIDTH-1:0] access_index,
    input  logic                   access_way,
    input  logic                   flush_req,
    output logic                   busy,
    output logic                   flush_done
);

    localparam logic [INDEX_WIDTH-1:0] C_LAST_SET = INDEX_WIDTH'(NUM_SETS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic                   r_busy;
    logic                   r_flush_done;
    logic [1:0]             r_lru [NUM_SETS];
    logic [1:0]             w_access_word;

    // One-hot MRU encoding: the accessed way's bit is the only one set.
    assign w_access_word = access_way ? 2'b10 : 2'b01;

    // Read returns the value stored at the start of the cycle (no bypass).
    assign current_lru = r_lru[rd_index];
    assign busy        = r_busy;
    assign flush_done  = r_flush_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_lru[i] <= 2'b00;
            end
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_busy       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // An access coinciding with flush_req still lands; the walk clears it later.
                    if (access_valid) begin
                        r_lru[access_index] <= w_access_word;
                    end
                    if (flush_req) begin
                        r_state <= ST_FLUSH;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    r_lru[r_ptr] <= 2'b00;
                    if (r_ptr == C_LAST_SET) begin
                        r_state      <= ST_IDLE;
                        r_ptr        <= '0;
                        r_busy       <= 1'b0;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/lru_state_table.md
# lru_state_table

Per-set LRU state storage for the 2-way set-associative cache. It holds one 2-bit LRU word per set and presents the addressed set's word on `current_lru`, which feeds `lower_lru_way_finder` directly. On each cache hit or fill it records which way was touched. A flush sequencer walks the table and clears it one set per cycle.

## Interface

Parameters:
- `INDEX_WIDTH`, default 2: set index width.
- `NUM_SETS`, default `2**INDEX_WIDTH`: number of sets. Must equal `2**INDEX_WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high. Clears every set to 2'b00, returns the FSM to IDLE and clears all outputs.
- `rd_index`  in  INDEX_WIDTH  set being looked up.
- `current_lru`  out  2  LRU word of `rd_index`. Combinational read of the stored array.
- `access_valid`  in  1  record an access this cycle.
- `access_index`  in  INDEX_WIDTH  set accessed.
- `access_way`  in  1  way accessed (0 or 1).
- `flush_req`  in  1  single-cycle request to clear the table.
- `busy`  out  1  high while flushing.
- `flush_done`  out  1  one-cycle pulse on the cycle after the last set is cleared.

## Operation

- Encoding: bit[w]=1 means way w is the most recently used.
  - 2'b00: reset/untouched; way0 is the victim.
  - 2'b01: way0 MRU; way1 is the victim.
  - 2'b10: way1 MRU; way0 is the victim.
  - 2'b11: must never be stored.
- Update: when `access_valid` is high and the FSM is IDLE, write `lru[access_index]`:
  - 2'b01 if `access_way`=0.
  - 2'b10 if `access_way`=1.
  - The write replaces the old value; it is not OR-ed with it.
- Read: `current_lru` = `lru[rd_index]` as stored at the start of the cycle. There is no same-cycle bypass: a read of the set being written returns the old value and sees the new value the next cycle.
- FSM states:
  - IDLE: accepts updates. `flush_req` moves to FLUSH with `ptr`=0 and sets `busy`. An `access_valid` in the same cycle is still applied, and is then overwritten when its set is cleared.
  - FLUSH: each cycle writes `lru[ptr]`=2'b00 and increments `ptr`. `access_valid` is ignored, and the caller must hold it low. `flush_req` is ignored. When `ptr`=NUM_SETS-1 is cleared, the next state is IDLE.
  - On the transition out of FLUSH, `busy` falls and `flush_done` pulses for one cycle.
- `ptr` is INDEX_WIDTH bits wide. The exit condition is tested on `ptr`==NUM_SETS-1, not on wrap-around.
- Reset mid-flush: the table is cleared, the FSM goes to IDLE, `busy`=0 and `flush_done`=0.
- Reset values: all `lru` entries=2'b00, `busy`=0, `flush_done`=0, `ptr`=0. `current_lru` reads 2'b00 for every index.

## Timing

- Update latency: a write in cycle N is visible on `current_lru` in cycle N+1.
- Flush:
  - `flush_req` sampled at edge E0 sets `busy` in cycle 1.
  - Set k is cleared at edge E(k+1).
  - `busy` is high for exactly NUM_SETS cycles.
  - `flush_done` is high in cycle NUM_SETS+1, the same cycle `busy` is low.
- Back-to-back updates to the same set: the last write wins, one write per cycle.
- Reset has priority over flush and update in the same cycle.

## Test plan

- Reset behaviour: assert `reset` for 1 cycle, then sweep `rd_index` 0..3 -> `current_lru`=2'b00 for all, `busy`=0, `flush_done`=0.
- Update encoding: access set 2 way0 -> next cycle `current_lru`(idx2)=2'b01. Then access way1 -> 2'b10. Sets 0, 1 and 3 stay 2'b00. 2'b11 never appears in any set.
- Read-during-write: set 1=2'b01; in one cycle, access set 1 way1 with `rd_index`=1 -> `current_lru`=2'b01 that cycle and 2'b10 the next.
- Flush: fill all 4 sets with non-zero values, pulse `flush_req` -> `busy` high for exactly 4 cycles, `flush_done` pulses in cycle 5, all sets read 2'b00. An `access_valid` issued while `busy` has no effect.
- Flush plus update in the same cycle: in IDLE, `flush_req` and an access to set 3 way1 together -> set 3 reads 2'b10 until its clear at cycle 4, then 2'b00.
- Reset mid-flush: assert `reset` in flush cycle 2 -> next cycle `busy`=0, all sets 2'b00, no `flush_done` pulse. A new `flush_req` then completes normally in 4 cycles.
